mpu_scalar_div: RTL and testbench
=================================

Name: mpu_scalar_div

Overview:
- Sequential element-wise division of a flattened 5x5 matrix of unsigned 8-bit integers by an unsigned 8-bit scalar divisor.
- Inverse companion to the MPU scalar-multiply path.
- Uses one shared restoring divider, iterated over all 25 elements under a start/busy/done handshake.
- Sits in the MPU execute stage beside the combinational element-wise units.

Parameters:
- DIM, 5, matrix rows and columns; element count N = DIM*DIM.
- ELEM_W, 8, element and divisor width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- matrix_a  input  N*ELEM_W (200)  dividend matrix; element k = DIM*row + col at bits [ELEM_W*k +: ELEM_W].
- divisor  input  ELEM_W  scalar divisor.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result is valid.
- div_by_zero  output  1  set for an operation whose divisor was 0; held until the next accepted start.
- result  output  N*ELEM_W  quotient matrix, same layout as matrix_a; held until the next accepted start.

Behaviour:
- Reset (synchronous, active-high; also mid-operation): state=IDLE; busy=0, done=0, div_by_zero=0, result=0; internal element counter, bit counter and partial remainder cleared. An operation in flight is abandoned.
- States: IDLE, DIV, DONE.
- IDLE or DONE with start=1: latch matrix_a and divisor.
  - divisor==0: go to DONE next cycle; result=all 0xFF; div_by_zero=1.
  - otherwise: go to DIV; busy=1; elem=0; bit=ELEM_W-1; div_by_zero=0.
- DONE with start=0: return to IDLE.
- start in DIV is ignored; the inputs are not re-sampled.
- DIV: one restoring step per cycle, MSB first.
  - Remainder r is ELEM_W+1 bits: r' = {r, dividend_bit}.
  - If r' >= divisor: q_bit=1 and r = r' - divisor; else q_bit=0 and r = r'.
  - After the ELEM_W-th step, write the quotient to result element elem, clear r, and advance elem.
  - After element N-1, go to DONE.
- Latency, nonzero divisor: busy is high for exactly N*ELEM_W = 200 cycles. done is high in the 201st cycle after the accepting edge; busy=0 in that cycle.
- Latency, zero divisor: done is high in the 1st cycle after the accepting edge; busy stays 0.
- result elements update in place during DIV. Only values present while done=1 are guaranteed.
- Arithmetic: unsigned; quotient = floor(a/d), fits ELEM_W; no overflow possible for d≥1.

Optional Feature:
- Macro: MPU_SCALAR_DIV_REMAINDER_EN.
- Defined:
  - Adds output port remainder, N*ELEM_W, same layout as result.
  - Each element holds a mod d, written alongside its quotient.
  - Divide-by-zero sets remainder = matrix_a; reset clears it to 0.
- Undefined: the port is absent; no remainder storage is inferred.

Decomposition:
- Shared include mpu_defs.vh:
  - DIM, ELEM_W, MATRIX_W constants.
  - Element-offset macro (ELEM_W*(DIM*row+col)).
  - The state encodings.
- One sub-module, mpu_div_step: combinational single restoring step.
  - In: r, dividend_bit, divisor. Out: r_next, q_bit.
  - Unit-testable on its own.
- FSM, counters and matrix registers stay in mpu_scalar_div.

Test Plan:
- Elements 2,4,...,50 (k=0..24), divisor=2, start pulse -> busy high 200 cycles; done in cycle 201; result elements 1..25; div_by_zero=0.
- Any matrix, divisor=0 -> done in cycle 1; busy never high; result all 0xFF; div_by_zero=1. With REMAINDER_EN: remainder==matrix_a.
- Elements 255,7,0,9,…, divisor=3 -> quotients 85,2,0,3. With REMAINDER_EN: remainders 0,1,0,0. Also 255/1 -> 255 and 5/255 -> 0.
- Start op1, pulse start with different data at cycle 50 of DIV -> ignored; op1 result unchanged; done at cycle 201.
- Assert rst at cycle 60 of DIV -> next cycle busy=0, done=0, result=0, IDLE. A fresh start then completes correctly in 201 cycles.
- start held high in the DONE cycle with new data -> accepted back-to-back; busy next cycle; second done exactly 201 cycles later; div_by_zero cleared.

Source files
------------

// File: rtl/mpu_scalar_div_pkg.sv
// mpu_scalar_div_pkg
// Shared constants, FSM state encoding and layout helper for the MPU
// scalar-divide block.
//   DIM       matrix rows/columns
//   ELEM_W    element and divisor width
//   N_ELEM    element count (DIM*DIM)
//   MATRIX_W  flattened matrix width
//   REM_W     partial-remainder width (ELEM_W+1)
// Optional feature macro used by the block: MPU_SCALAR_DIV_REMAINDER_EN.
package mpu_scalar_div_pkg;

    localparam int DIM      = 5;
    localparam int ELEM_W   = 8;
    localparam int N_ELEM   = DIM * DIM;
    localparam int MATRIX_W = N_ELEM * ELEM_W;
    localparam int REM_W    = ELEM_W + 1;
    localparam int CNT_W    = $clog2(N_ELEM);
    localparam int BIT_W    = $clog2(ELEM_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit offset of element (row, col) in a flattened matrix.
    function automatic int elem_off(input int row, input int col);
        return ELEM_W * (DIM * row + col);
    endfunction

endpackage

// File: rtl/mpu_scalar_div_if.sv
// mpu_scalar_div_if
// Handshake and data bundle of the scalar-divide unit.
//   start        request, sampled by the unit only in IDLE or DONE
//   matrix_a     flattened dividend matrix (element k at [ELEM_W*k +: ELEM_W])
//   divisor      scalar divisor
//   busy         operation in progress
//   done         one-cycle pulse, result valid
//   div_by_zero  last accepted operation had divisor 0
//   result       flattened quotient matrix
//   remainder    flattened remainder matrix (only with MPU_SCALAR_DIV_REMAINDER_EN)
// master: requester side; slave: the divide unit.
interface mpu_scalar_div_if;
    import mpu_scalar_div_pkg::*;

    logic                start;
    logic [MATRIX_W-1:0] matrix_a;
    logic [ELEM_W-1:0]   divisor;
    logic                busy;
    logic                done;
    logic                div_by_zero;
    logic [MATRIX_W-1:0] result;
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
    logic [MATRIX_W-1:0] remainder;

    modport master (output start, matrix_a, divisor,
                    input  busy, done, div_by_zero, result, remainder);
    modport slave  (input  start, matrix_a, divisor,
                    output busy, done, div_by_zero, result, remainder);
`else
    modport master (output start, matrix_a, divisor,
                    input  busy, done, div_by_zero, result);
    modport slave  (input  start, matrix_a, divisor,
                    output busy, done, div_by_zero, result);
`endif

endinterface

// File: rtl/mpu_div_step.sv
// mpu_div_step
// One combinational restoring-division step.
//   r_i             partial remainder (REM_W bits)
//   dividend_bit_i  next dividend bit, MSB first
//   divisor_i       divisor
//   r_next_o        updated partial remainder
//   q_bit_o         quotient bit produced by this step
module mpu_div_step
    import mpu_scalar_div_pkg::*;
(
    input  logic [REM_W-1:0]  r_i,
    input  logic              dividend_bit_i,
    input  logic [ELEM_W-1:0] divisor_i,
    output logic [REM_W-1:0]  r_next_o,
    output logic              q_bit_o
);

    // One bit wider than the remainder so the shifted value never truncates.
    logic [REM_W:0] trial_s;

    // Shift in the dividend bit, subtract the divisor when it fits.
    always_comb begin
        trial_s  = {r_i, dividend_bit_i};
        r_next_o = {REM_W{1'b0}};
        q_bit_o  = 1'b0;
        if (trial_s >= {2'b00, divisor_i}) begin
            q_bit_o  = 1'b1;
            r_next_o = REM_W'(trial_s - {2'b00, divisor_i});
        end else begin
            q_bit_o  = 1'b0;
            r_next_o = trial_s[REM_W-1:0];
        end
    end

endmodule

// File: rtl/mpu_scalar_div.sv
// mpu_scalar_div
// Element-wise division of a flattened DIM x DIM matrix by a scalar, using
// one shared restoring divider stepped one bit per cycle over all elements.
//   clk     rising-edge clock
//   rst     synchronous active-high reset (abandons an operation in flight)
//   div_if  mpu_scalar_div_if.slave: start/matrix_a/divisor in,
//           busy/done/div_by_zero/result (and remainder) out
// Optional feature: define MPU_SCALAR_DIV_REMAINDER_EN to add the remainder
// output matrix (a mod d per element; matrix_a on divide-by-zero).
module mpu_scalar_div
    import mpu_scalar_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mpu_scalar_div_if.slave div_if
);

    state_e              state_q;
    logic [MATRIX_W-1:0] a_q;
    logic [ELEM_W-1:0]   d_q;
    logic [CNT_W-1:0]    elem_q;
    logic [BIT_W-1:0]    bit_q;
    logic [REM_W-1:0]    rem_q;
    logic [ELEM_W-2:0]   quo_q;     // quotient bits collected so far for the current element
    logic [MATRIX_W-1:0] result_q;
    logic                busy_q;
    logic                done_q;
    logic                dbz_q;
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
    logic [MATRIX_W-1:0] rem_out_q;
`endif

    logic [ELEM_W-1:0]   cur_elem_s;
    logic                dividend_bit_s;
    logic [REM_W-1:0]    r_next_s;
    logic                q_bit_s;
    logic [ELEM_W-1:0]   quo_d;

    // Select the dividend element currently being divided and its next bit.
    always_comb begin
        cur_elem_s = {ELEM_W{1'b0}};
        for (int k = 0; k < N_ELEM; k++) begin
            cur_elem_s = (elem_q == CNT_W'(k)) ? a_q[k*ELEM_W +: ELEM_W] : cur_elem_s;
        end
        dividend_bit_s = cur_elem_s[bit_q];
        quo_d          = {quo_q, q_bit_s};
    end

    mpu_div_step u_step (
        .r_i            (rem_q),
        .dividend_bit_i (dividend_bit_s),
        .divisor_i      (d_q),
        .r_next_o       (r_next_s),
        .q_bit_o        (q_bit_s)
    );

    // Control FSM with counters, operand latches and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= {MATRIX_W{1'b0}};
            d_q       <= {ELEM_W{1'b0}};
            elem_q    <= {CNT_W{1'b0}};
            bit_q     <= {BIT_W{1'b0}};
            rem_q     <= {REM_W{1'b0}};
            quo_q     <= {(ELEM_W-1){1'b0}};
            result_q  <= {MATRIX_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
            rem_out_q <= {MATRIX_W{1'b0}};
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (div_if.start) begin
                        a_q    <= div_if.matrix_a;
                        d_q    <= div_if.divisor;
                        elem_q <= {CNT_W{1'b0}};
                        bit_q  <= BIT_W'(ELEM_W - 1);
                        rem_q  <= {REM_W{1'b0}};
                        quo_q  <= {(ELEM_W-1){1'b0}};
                        if (div_if.divisor == {ELEM_W{1'b0}}) begin
                            // Divide-by-zero completes immediately with saturated quotients.
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                            dbz_q     <= 1'b1;
                            result_q  <= {MATRIX_W{1'b1}};
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
                            rem_out_q <= div_if.matrix_a;
`endif
                        end else begin
                            state_q <= ST_DIV;
                            busy_q  <= 1'b1;
                            dbz_q   <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    rem_q <= r_next_s;
                    quo_q <= quo_d[ELEM_W-2:0];
                    if (bit_q == {BIT_W{1'b0}}) begin
                        // Last bit of this element: commit it and move on.
                        for (int k = 0; k < N_ELEM; k++) begin
                            if (elem_q == CNT_W'(k)) begin
                                result_q[k*ELEM_W +: ELEM_W] <= quo_d;
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
                                rem_out_q[k*ELEM_W +: ELEM_W] <= r_next_s[ELEM_W-1:0];
`endif
                            end
                        end
                        rem_q <= {REM_W{1'b0}};
                        quo_q <= {(ELEM_W-1){1'b0}};
                        bit_q <= BIT_W'(ELEM_W - 1);
                        if (elem_q == CNT_W'(N_ELEM - 1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            elem_q  <= {CNT_W{1'b0}};
                        end else begin
                            elem_q <= elem_q + CNT_W'(1);
                        end
                    end else begin
                        bit_q <= bit_q - BIT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign div_if.busy        = busy_q;
    assign div_if.done        = done_q;
    assign div_if.div_by_zero = dbz_q;
    assign div_if.result      = result_q;
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
    assign div_if.remainder   = rem_out_q;
`endif

endmodule

// File: tb/tb_mpu_scalar_div.sv
// tb_mpu_scalar_div
// Directed testbench for mpu_scalar_div: reset state, latency, quotient
// values, divide-by-zero, ignored start, mid-operation reset and
// back-to-back starts. Remainder checks are active with
// MPU_SCALAR_DIV_REMAINDER_EN.
module tb_mpu_scalar_div;
    import mpu_scalar_div_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mpu_scalar_div_if bus ();

    mpu_scalar_div dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [MATRIX_W-1:0] m_a, m_b, m_c, m_d, m_e;
    logic [MATRIX_W-1:0] q_a, q_c, q_d, q_e;
    logic [MATRIX_W-1:0] r_c, r_d, r_e;
    int done_cyc;
    int busy_cnt;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int off_k(input int k);
        return elem_off(k / DIM, k % DIM);
    endfunction

    // Present operands with start high; the next rising edge accepts them.
    task automatic pulse_start(input logic [MATRIX_W-1:0] m, input logic [ELEM_W-1:0] d);
        @(negedge clk);
        bus.matrix_a = m;
        bus.divisor  = d;
        bus.start    = 1'b1;
    endtask

    // Count cycles after the accepting edge until done (bounded); optionally
    // pulse start with other data at cycle inj_cyc.
    task automatic wait_done(input int inj_cyc, input logic [MATRIX_W-1:0] inj_m,
                             input logic [ELEM_W-1:0] inj_d,
                             output int dcyc, output int bcnt);
        dcyc = -1;
        bcnt = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.start = 1'b0;
            if (cyc == inj_cyc) begin
                bus.matrix_a = inj_m;
                bus.divisor  = inj_d;
                bus.start    = 1'b1;
            end
            if (cyc == inj_cyc + 1) bus.start = 1'b0;
            if (bus.busy) bcnt++;
            if (bus.done) begin
                dcyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        // Operand and hand-computed expectation tables.
        for (int k = 0; k < N_ELEM; k++) begin
            m_a[off_k(k) +: ELEM_W] = ELEM_W'(2 * k + 2);
            q_a[off_k(k) +: ELEM_W] = ELEM_W'(k + 1);
            m_b[off_k(k) +: ELEM_W] = ELEM_W'(3 * k + 1);
            m_c[off_k(k) +: ELEM_W] = 8'd100;
            q_c[off_k(k) +: ELEM_W] = 8'd33;
            r_c[off_k(k) +: ELEM_W] = 8'd1;
            m_d[off_k(k) +: ELEM_W] = 8'd255;
            q_d[off_k(k) +: ELEM_W] = 8'd255;
            r_d[off_k(k) +: ELEM_W] = 8'd0;
            m_e[off_k(k) +: ELEM_W] = 8'd254;
            q_e[off_k(k) +: ELEM_W] = 8'd0;
            r_e[off_k(k) +: ELEM_W] = 8'd254;
        end
        m_c[off_k(0) +: 8] = 8'd255; q_c[off_k(0) +: 8] = 8'd85; r_c[off_k(0) +: 8] = 8'd0;
        m_c[off_k(1) +: 8] = 8'd7;   q_c[off_k(1) +: 8] = 8'd2;  r_c[off_k(1) +: 8] = 8'd1;
        m_c[off_k(2) +: 8] = 8'd0;   q_c[off_k(2) +: 8] = 8'd0;  r_c[off_k(2) +: 8] = 8'd0;
        m_c[off_k(3) +: 8] = 8'd9;   q_c[off_k(3) +: 8] = 8'd3;  r_c[off_k(3) +: 8] = 8'd0;
        m_c[off_k(4) +: 8] = 8'd255; q_c[off_k(4) +: 8] = 8'd85; r_c[off_k(4) +: 8] = 8'd0;
        m_c[off_k(5) +: 8] = 8'd5;   q_c[off_k(5) +: 8] = 8'd1;  r_c[off_k(5) +: 8] = 8'd2;
        m_d[off_k(24) +: 8] = 8'd0;  q_d[off_k(24) +: 8] = 8'd0;
        m_e[off_k(0) +: 8] = 8'd5;   q_e[off_k(0) +: 8] = 8'd0;  r_e[off_k(0) +: 8] = 8'd5;
        m_e[off_k(1) +: 8] = 8'd255; q_e[off_k(1) +: 8] = 8'd1;  r_e[off_k(1) +: 8] = 8'd0;

        bus.start    = 1'b0;
        bus.matrix_a = '0;
        bus.divisor  = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 256'(bus.busy), 256'd0);
        check_val("rst_done", 256'(bus.done), 256'd0);
        check_val("rst_dbz", 256'(bus.div_by_zero), 256'd0);
        check_val("rst_result", 256'(bus.result), 256'd0);
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
        check_val("rst_rem", 256'(bus.remainder), 256'd0);
`endif
        rst = 1'b0;

        // Even ramp divided by 2.
        pulse_start(m_a, 8'd2);
        wait_done(-1, m_a, 8'd0, done_cyc, busy_cnt);
        check_val("a_done_cyc", 256'(done_cyc), 256'd201);
        check_val("a_busy_cnt", 256'(busy_cnt), 256'd200);
        check_val("a_result", 256'(bus.result), 256'(q_a));
        check_val("a_dbz", 256'(bus.div_by_zero), 256'd0);
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
        check_val("a_rem", 256'(bus.remainder), 256'd0);
`endif
        @(negedge clk);
        check_val("a_done_pulse", 256'(bus.done), 256'd0);
        check_val("a_result_held", 256'(bus.result), 256'(q_a));

        // Divide by zero.
        pulse_start(m_b, 8'd0);
        wait_done(-1, m_b, 8'd0, done_cyc, busy_cnt);
        check_val("z_done_cyc", 256'(done_cyc), 256'd1);
        check_val("z_busy_cnt", 256'(busy_cnt), 256'd0);
        check_val("z_result", 256'(bus.result), 256'({MATRIX_W{1'b1}}));
        check_val("z_dbz", 256'(bus.div_by_zero), 256'd1);
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
        check_val("z_rem", 256'(bus.remainder), 256'(m_b));
`endif
        @(negedge clk);
        check_val("z_done_pulse", 256'(bus.done), 256'd0);
        check_val("z_dbz_held", 256'(bus.div_by_zero), 256'd1);

        // Mixed values divided by 3, then d=1 and d=255 boundaries.
        pulse_start(m_c, 8'd3);
        wait_done(-1, m_c, 8'd0, done_cyc, busy_cnt);
        check_val("c_done_cyc", 256'(done_cyc), 256'd201);
        check_val("c_result", 256'(bus.result), 256'(q_c));
        check_val("c_dbz", 256'(bus.div_by_zero), 256'd0);
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
        check_val("c_rem", 256'(bus.remainder), 256'(r_c));
`endif
        pulse_start(m_d, 8'd1);
        wait_done(-1, m_d, 8'd0, done_cyc, busy_cnt);
        check_val("d_done_cyc", 256'(done_cyc), 256'd201);
        check_val("d_result", 256'(bus.result), 256'(q_d));
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
        check_val("d_rem", 256'(bus.remainder), 256'(r_d));
`endif
        pulse_start(m_e, 8'd255);
        wait_done(-1, m_e, 8'd0, done_cyc, busy_cnt);
        check_val("e_done_cyc", 256'(done_cyc), 256'd201);
        check_val("e_result", 256'(bus.result), 256'(q_e));
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
        check_val("e_rem", 256'(bus.remainder), 256'(r_e));
`endif

        // Start during DIV with other data must be ignored.
        pulse_start(m_a, 8'd2);
        wait_done(50, m_b, 8'd0, done_cyc, busy_cnt);
        check_val("ign_done_cyc", 256'(done_cyc), 256'd201);
        check_val("ign_busy_cnt", 256'(busy_cnt), 256'd200);
        check_val("ign_result", 256'(bus.result), 256'(q_a));
        check_val("ign_dbz", 256'(bus.div_by_zero), 256'd0);

        // Reset in the middle of an operation.
        pulse_start(m_b, 8'd1);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.start = 1'b0;
        end
        check_val("mid_busy_before", 256'(bus.busy), 256'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_busy", 256'(bus.busy), 256'd0);
        check_val("mid_rst_done", 256'(bus.done), 256'd0);
        check_val("mid_rst_result", 256'(bus.result), 256'd0);
`ifdef MPU_SCALAR_DIV_REMAINDER_EN
        check_val("mid_rst_rem", 256'(bus.remainder), 256'd0);
`endif
        pulse_start(m_c, 8'd3);
        wait_done(-1, m_c, 8'd0, done_cyc, busy_cnt);
        check_val("post_rst_done_cyc", 256'(done_cyc), 256'd201);
        check_val("post_rst_result", 256'(bus.result), 256'(q_c));

        // Back-to-back: start held high in the DONE cycle of a divide-by-zero.
        pulse_start(m_b, 8'd0);
        wait_done(-1, m_b, 8'd0, done_cyc, busy_cnt);
        check_val("b2b_first_done", 256'(done_cyc), 256'd1);
        check_val("b2b_first_dbz", 256'(bus.div_by_zero), 256'd1);
        bus.matrix_a = m_a;
        bus.divisor  = 8'd2;
        bus.start    = 1'b1;
        wait_done(-1, m_a, 8'd0, done_cyc, busy_cnt);
        check_val("b2b_done_cyc", 256'(done_cyc), 256'd201);
        check_val("b2b_busy_cnt", 256'(busy_cnt), 256'd200);
        check_val("b2b_result", 256'(bus.result), 256'(q_a));
        check_val("b2b_dbz", 256'(bus.div_by_zero), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
